// File: rtl/sa_buffer_loader.sv
// Packs a scalar element stream into NUM_ROW- or NUM_COL-lane words and writes them
// to consecutive addresses of the left or top systolic-array buffer.
module sa_buffer_loader #(
    parameter int NUM_ROW              = 4,
    parameter int NUM_COL              = 4,
    parameter int DATA_WIDTH           = 8,
    parameter int LOG2_SRAM_BANK_DEPTH = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_start,
    input  logic                                  i_sel,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]       i_base_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]       i_num_words,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATA_WIDTH-1:0]                 s_data,
    output logic                                  o_left_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]       o_left_wr_addr,
    output logic [NUM_ROW*DATA_WIDTH-1:0]         o_left_wr_data,
    output logic                                  o_top_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]       o_top_wr_addr,
    output logic [NUM_COL*DATA_WIDTH-1:0]         o_top_wr_data,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]       o_end_addr
);

    localparam int AW   = LOG2_SRAM_BANK_DEPTH;
    localparam int MAXL = (NUM_ROW > NUM_COL) ? NUM_ROW : NUM_COL;
    localparam int LW   = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam int PW   = MAXL * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state;
    logic            sel;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   words_left;
    logic [LW-1:0]   lane;
    logic [PW-1:0]   pack;

    logic [LW-1:0]   last_lane;
    logic [PW-1:0]   word;
    logic            hs;

    always_comb begin
        last_lane = sel ? LW'(NUM_COL - 1) : LW'(NUM_ROW - 1);
        word      = pack;
        word[lane*DATA_WIDTH +: DATA_WIDTH] = s_data;
        hs        = s_ready && s_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sel            <= 1'b0;
            addr           <= '0;
            words_left     <= '0;
            lane           <= '0;
            pack           <= '0;
            s_ready        <= 1'b0;
            o_left_wr_en   <= 1'b0;
            o_left_wr_addr <= '0;
            o_left_wr_data <= '0;
            o_top_wr_en    <= 1'b0;
            o_top_wr_addr  <= '0;
            o_top_wr_data  <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_end_addr     <= '0;
        end else begin
            o_left_wr_en <= 1'b0;
            o_top_wr_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sel        <= i_sel;
                        addr       <= i_base_addr;
                        words_left <= i_num_words;
                        lane       <= '0;
                        o_busy     <= 1'b1;
                        if (i_num_words == '0) begin
                            state      <= DONE;
                            o_done     <= 1'b1;
                            o_end_addr <= i_base_addr - AW'(1);
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // s_ready low in LOAD marks the cycle in which the final word is being written
                    if (!s_ready) begin
                        state      <= DONE;
                        o_done     <= 1'b1;
                        o_end_addr <= addr - AW'(1);
                    end else if (hs) begin
                        pack <= word;
                        if (lane == last_lane) begin
                            lane       <= '0;
                            addr       <= addr + AW'(1);
                            words_left <= words_left - AW'(1);
                            if (sel) begin
                                o_top_wr_en   <= 1'b1;
                                o_top_wr_addr <= addr;
                                o_top_wr_data <= word[NUM_COL*DATA_WIDTH-1:0];
                            end else begin
                                o_left_wr_en   <= 1'b1;
                                o_left_wr_addr <= addr;
                                o_left_wr_data <= word[NUM_ROW*DATA_WIDTH-1:0];
                            end
                            if (words_left == AW'(1)) s_ready <= 1'b0;
                        end else begin
                            lane <= lane + LW'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
